// File: rtl/psram_qspi_rsp.sv
// QSPI PSRAM responder: decodes command/address/wait/data from the controller's
// SCK/CE/IO and serves quad reads and writes from an internal byte array.
module psram_qspi_rsp #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [7:0]  WR_CMD    = 8'h38,
    parameter logic [7:0]  RD_CMD    = 8'hEB,
    parameter int unsigned WR_WAIT   = 0,
    parameter int unsigned RD_WAIT   = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [3:0] psram_io_in_i,
    output logic [3:0] psram_io_out_o,
    output logic       psram_io_en_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_WDAT, S_RDAT, S_SKIP
    } state_t;

    state_t         state;
    logic           sck_q;
    logic [CW-1:0]  nib_cnt;
    logic [19:0]    shreg;
    logic           is_rd;
    logic           phase;
    logic [3:0]     hi_nib;
    logic [AW-1:0]  addr;
    logic [7:0]     mem [MEM_DEPTH];

    logic           rise_c;
    logic           fall_c;
    logic [7:0]     opcode_c;
    logic [CW-1:0]  wait_last_c;
    logic           wait_zero_c;
    state_t         data_st_c;
    logic           mem_we_c;
    logic [7:0]     rd_byte_c;

    always_comb begin
        rise_c      = psram_sck_i & ~sck_q;
        fall_c      = ~psram_sck_i & sck_q;
        opcode_c    = {shreg[3:0], psram_io_in_i};
        wait_last_c = is_rd ? CW'(RD_WAIT - 1) : CW'(WR_WAIT - 1);
        wait_zero_c = is_rd ? (RD_WAIT == 0) : (WR_WAIT == 0);
        data_st_c   = is_rd ? S_RDAT : S_WDAT;
        mem_we_c    = !rst_i && !psram_ce_i && (state == S_WDAT) && rise_c && phase;
        rd_byte_c   = mem[addr];
    end

    // Byte store; not reset, contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem[addr] <= {hi_nib, psram_io_in_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            sck_q          <= 1'b0;
            nib_cnt        <= '0;
            shreg          <= '0;
            is_rd          <= 1'b0;
            phase          <= 1'b0;
            hi_nib         <= '0;
            addr           <= '0;
            psram_io_out_o <= '0;
            psram_io_en_o  <= 1'b0;
            busy_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            sck_q <= psram_sck_i;
            err_o <= 1'b0;
            // Deselect wins over any SCK edge in the same cycle.
            if (psram_ce_i) begin
                state          <= S_IDLE;
                nib_cnt        <= '0;
                phase          <= 1'b0;
                psram_io_out_o <= '0;
                psram_io_en_o  <= 1'b0;
                busy_o         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_CMD;
                        nib_cnt <= '0;
                        phase   <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                    S_CMD: if (rise_c) begin
                        shreg   <= {shreg[15:0], psram_io_in_i};
                        nib_cnt <= nib_cnt + CW'(1);
                        if (nib_cnt == CW'(1)) begin
                            nib_cnt <= '0;
                            if (opcode_c == WR_CMD) begin
                                state <= S_ADDR;
                                is_rd <= 1'b0;
                            end else if (opcode_c == RD_CMD) begin
                                state <= S_ADDR;
                                is_rd <= 1'b1;
                            end else begin
                                state <= S_SKIP;
                                err_o <= 1'b1;
                            end
                        end
                    end
                    S_ADDR: if (rise_c) begin
                        shreg   <= {shreg[15:0], psram_io_in_i};
                        nib_cnt <= nib_cnt + CW'(1);
                        if (nib_cnt == CW'(5)) begin
                            nib_cnt <= '0;
                            phase   <= 1'b0;
                            addr    <= AW'({shreg, psram_io_in_i});
                            state   <= wait_zero_c ? data_st_c : S_WAIT;
                        end
                    end
                    S_WAIT: if (rise_c) begin
                        nib_cnt <= nib_cnt + CW'(1);
                        if (nib_cnt == wait_last_c) begin
                            nib_cnt <= '0;
                            phase   <= 1'b0;
                            state   <= data_st_c;
                        end
                    end
                    // High nibble is held until the low nibble arrives and the byte commits.
                    S_WDAT: if (rise_c) begin
                        if (!phase) begin
                            hi_nib <= psram_io_in_i;
                            phase  <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            addr  <= addr + AW'(1);
                        end
                    end
                    S_RDAT: if (fall_c) begin
                        psram_io_en_o <= 1'b1;
                        if (!phase) begin
                            psram_io_out_o <= rd_byte_c[7:4];
                            phase          <= 1'b1;
                        end else begin
                            psram_io_out_o <= rd_byte_c[3:0];
                            phase          <= 1'b0;
                            addr           <= addr + AW'(1);
                        end
                    end
                    S_SKIP: begin
                        psram_io_en_o <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_qspi_rsp.sv
// Bench for psram_qspi_rsp: two builds (default waits, and RD_WAIT=0/WR_WAIT=2)
// driven through a bit-level controller model and checked against a byte-array model.
module tb_psram_qspi_rsp;

    localparam int unsigned DEPTH = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       ce_a;
    logic       ce_b;
    logic [3:0] io_in;
    logic [3:0] out_a, out_b;
    logic       en_a, en_b, busy_a, busy_b, err_a, err_b;

    always #5 clk = ~clk;

    psram_qspi_rsp dut_a (
        .clk_i(clk), .rst_i(rst), .psram_sck_i(sck), .psram_ce_i(ce_a),
        .psram_io_in_i(io_in), .psram_io_out_o(out_a), .psram_io_en_o(en_a),
        .busy_o(busy_a), .err_o(err_a)
    );

    psram_qspi_rsp #(.RD_WAIT(0), .WR_WAIT(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .psram_sck_i(sck), .psram_ce_i(ce_b),
        .psram_io_in_i(io_in), .psram_io_out_o(out_b), .psram_io_en_o(en_b),
        .busy_o(busy_b), .err_o(err_b)
    );

    logic       cur;
    logic [3:0] cur_out;
    logic       cur_en, cur_busy, cur_err;
    always_comb begin
        cur_out  = cur ? out_b  : out_a;
        cur_en   = cur ? en_b   : en_a;
        cur_busy = cur ? busy_b : busy_a;
        cur_err  = cur ? err_b  : err_a;
    end

    logic [7:0] model [2][DEPTH];
    int n_checks = 0;
    int n_errors = 0;
    int err_seen [2] = '{0, 0};
    int err_exp  [2] = '{0, 0};

    always @(posedge clk) begin
        if (err_a) err_seen[0]++;
        if (err_b) err_seen[1]++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut=%0d got=%0h exp=%0h", tag, cur, got, exp);
        end
    endtask

    function automatic int rd_wait();
        return cur ? 0 : 6;
    endfunction

    function automatic int wr_wait();
        return cur ? 2 : 0;
    endfunction

    task automatic set_ce(input logic v);
        if (cur) ce_b = v;
        else     ce_a = v;
    endtask

    task automatic sck_rise(input logic [3:0] nib);
        io_in = nib;
        sck   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic sck_fall();
        sck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] nib);
        sck_rise(nib);
        sck_fall();
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse(b[7:4]);
        pulse(b[3:0]);
    endtask

    task automatic ce_low();
        set_ce(1'b0);
        @(negedge clk);
        chk("busy_on", 32'(cur_busy), 32'd1);
    endtask

    task automatic ce_high();
        set_ce(1'b1);
        @(negedge clk);
        chk("busy_off", 32'(cur_busy), 32'd0);
        chk("en_off", 32'(cur_en), 32'd0);
        chk("out_off", 32'(cur_out), 32'd0);
        @(negedge clk);
    endtask

    function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
        logic [7:0] b;
        b = model[cur][(int'(a) + k / 2) % DEPTH];
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    task automatic do_write(input logic [23:0] a, input logic [7:0] d[$], input logic abort_hi);
        ce_low();
        send_byte(8'h38);
        for (int i = 0; i < 6; i++) pulse(a[23 - 4 * i -: 4]);
        repeat (wr_wait()) pulse(4'($urandom));
        foreach (d[i]) begin
            send_byte(d[i]);
            model[cur][(int'(a) + i) % DEPTH] = d[i];
        end
        if (abort_hi) pulse(4'($urandom));
        ce_high();
    endtask

    task automatic do_read(input logic [23:0] a, input int len);
        logic [3:0] entry_nib;
        ce_low();
        send_byte(8'hEB);
        for (int i = 0; i < 5; i++) pulse(a[23 - 4 * i -: 4]);
        if (rd_wait() == 0) begin
            entry_nib = a[3:0];
        end else begin
            pulse(a[3:0]);
            repeat (rd_wait() - 1) pulse(4'h0);
            entry_nib = 4'h0;
        end
        chk("en_before_entry", 32'(cur_en), 32'd0);
        sck_rise(entry_nib);
        chk("en_after_entry_rise", 32'(cur_en), 32'd0);
        sck_fall();
        chk("en_first_fall", 32'(cur_en), 32'd1);
        chk("rd_nib", 32'(cur_out), 32'(exp_nib(a, 0)));
        for (int k = 1; k < 2 * len; k++) begin
            pulse(4'($urandom));
            chk("rd_nib", 32'(cur_out), 32'(exp_nib(a, k)));
        end
        ce_high();
    endtask

    task automatic bad_cmd(input logic [7:0] op, input int extra);
        ce_low();
        pulse(op[7:4]);
        io_in = op[3:0];
        sck   = 1'b1;
        @(negedge clk);
        chk("err_pulse", 32'(cur_err), 32'd1);
        @(negedge clk);
        chk("err_one_cycle", 32'(cur_err), 32'd0);
        sck_fall();
        err_exp[cur]++;
        repeat (extra) begin
            pulse(4'hF);
            chk("skip_en", 32'(cur_en), 32'd0);
        end
        ce_high();
    endtask

    initial begin
        logic [7:0] q [$];
        rst = 1'b1; sck = 1'b0; ce_a = 1'b1; ce_b = 1'b1; io_in = '0; cur = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_en_a", 32'(en_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_en_b", 32'(en_b), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Preload both arrays with zeros through the write path.
        for (int c = 0; c < 2; c++) begin
            cur = 1'(c);
            q = {};
            for (int i = 0; i < DEPTH; i++) q.push_back(8'h00);
            do_write(24'h000000, q, 1'b0);
        end

        cur = 1'b0;
        q = {8'hA5, 8'h3C, 8'h7E, 8'h01};
        do_write(24'h000010, q, 1'b0);
        do_read(24'h000010, 4);

        q = {8'h11, 8'h22};
        do_write(24'h0003FF, q, 1'b0);
        do_read(24'h0003FF, 2);
        do_read(24'h000000, 1);

        bad_cmd(8'h9F, 9);
        do_read(24'h000010, 4);
        q = {8'h5A, 8'hC3};
        do_write(24'h000020, q, 1'b0);
        do_read(24'h000020, 2);

        q = {8'hB7};
        do_write(24'h000040, q, 1'b1);
        do_read(24'h000040, 2);

        // Reset in the middle of a read burst.
        ce_low();
        send_byte(8'hEB);
        for (int i = 0; i < 6; i++) pulse(4'(i == 4 ? 1 : 0));
        repeat (6) pulse(4'h0);
        pulse(4'h0);
        chk("pre_rst_en", 32'(en_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_en", 32'(en_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_out", 32'(out_a), 32'd0);
        ce_high();
        do_read(24'h000010, 1);

        cur = 1'b1;
        q = {8'hDE, 8'hAD, 8'hBE};
        do_write(24'h000100, q, 1'b0);
        do_read(24'h000100, 3);
        q = {8'h11, 8'h22};
        do_write(24'h0003FF, q, 1'b0);
        do_read(24'h0003FF, 2);

        for (int t = 0; t < 40; t++) begin
            int kind;
            int len;
            logic [23:0] a;
            logic [7:0] op;
            cur  = 1'($urandom);
            kind = int'($urandom_range(0, 7));
            len  = int'($urandom_range(1, 6));
            a    = 24'($urandom);
            if (kind == 0) begin
                do op = 8'($urandom); while (op == 8'h38 || op == 8'hEB);
                bad_cmd(op, int'($urandom_range(0, 4)));
            end else if (kind <= 3) begin
                q = {};
                for (int i = 0; i < len; i++) q.push_back(8'($urandom));
                do_write(a, q, 1'(kind == 1));
            end else begin
                do_read(a, len);
            end
        end

        cur = 1'b0;
        chk("err_count_a", 32'(err_seen[0]), 32'(err_exp[0]));
        cur = 1'b1;
        chk("err_count_b", 32'(err_seen[1]), 32'(err_exp[1]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psram_qspi_rsp.md
Name: psram_qspi_rsp

Overview:
- Synthesizable QSPI PSRAM responder: the device end of the PSRAM serial interface driven by psram_core.
- Decodes command, 24-bit address, wait cycles and quad data from the controller's SCK/CE/IO.
- Serves reads and writes from an internal byte array.
- Used as the in-fabric PSRAM target for FPGA bring-up and for closed-loop verification of the controller.

Parameters:
- MEM_DEPTH, 1024, bytes of internal storage; power of two; address taken modulo MEM_DEPTH.
- WR_CMD, 8'h38, quad write command opcode.
- RD_CMD, 8'hEB, quad fast-read command opcode.
- WR_WAIT, 0, SCK cycles between last address nibble and first write-data nibble.
- RD_WAIT, 6, SCK cycles between last address nibble and first read-data nibble.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- psram_sck_i  in  1  serial clock from controller, synchronous to clk_i.
- psram_ce_i  in  1  chip enable from controller, active low.
- psram_io_in_i  in  4  quad data from controller.
- psram_io_out_o  out  4  quad data driven by responder.
- psram_io_en_o  out  1  responder drive enable, 1 = responder owns IO.
- busy_o  out  1  high while a transaction is selected (CE low, state not IDLE).
- err_o  out  1  one-cycle pulse when an unsupported opcode is decoded.

Behaviour:
- Interface decision (fixed): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: psram_io_out_o=0, psram_io_en_o=0, busy_o=0, err_o=0, state=IDLE, counters=0, sck_q=0. Memory contents are not reset.
- SCK edge detection: sck_q is registered psram_sck_i. rise = sck & ~sck_q; fall = ~sck & sck_q.
- Input requirement: SCK high and low phases each last >=2 clk_i cycles.
- Controller drives IO on SCK fall; responder samples on rise. Responder updates IO on SCK fall.
- All multi-nibble fields are MSB nibble first.
- States:
  - IDLE: on CE low, go to CMD; nib_cnt=0; busy_o=1 from the next cycle.
  - CMD: 2 rises shift the opcode. On the 2nd rise:
    - opcode==WR_CMD -> ADDR, op=write.
    - opcode==RD_CMD -> ADDR, op=read.
    - otherwise -> SKIP, with err_o=1 for one cycle.
  - ADDR: 6 rises shift a 24-bit address. On the 6th rise, latch addr = addr[log2(MEM_DEPTH)-1:0]. Then:
    - go to WAIT if the op's wait count is >0;
    - otherwise go to WDAT (write) or RDAT (read).
  - WAIT: count rises up to WR_WAIT or RD_WAIT, then go to WDAT or RDAT.
  - WDAT: rise 1 latches the high nibble. Rise 2 writes byte {hi,lo} to mem[addr] in the same clk_i cycle, then addr=addr+1 with wrap MEM_DEPTH-1 -> 0. Repeat.
  - RDAT:
    - On the first fall after entry: psram_io_en_o=1, out=mem[addr][7:4].
    - Next fall: out=mem[addr][3:0], then addr+1 (wrap).
    - Alternate indefinitely.
    - Entry rise and first fall are distinct edges, so with RD_WAIT=0 data starts at the fall after the last address rise.
  - SKIP: ignore SCK and IO; psram_io_en_o=0.
- CE high in any state: next cycle state=IDLE, psram_io_en_o=0, psram_io_out_o=0, busy_o=0.
  - Takes priority over a simultaneous SCK edge.
  - A partially received write byte (high nibble only) is discarded; memory is unchanged.
- rst_i mid-transaction: same as reset; outputs take reset values the next cycle. A subsequent CE low starts a fresh CMD phase.
- psram_io_en_o is never 1 outside RDAT.
- No back-pressure. Unlimited burst length; data wraps within MEM_DEPTH.
- Memory: single-port behavioural array.
  - Write happens on the second WDAT nibble.
  - Read data is combinational from mem[addr], registered onto psram_io_out_o at the fall.
- Reads of never-written bytes return array contents, which are uninitialised in silicon. The bench preloads 0.

Test Plan:
- Quad write/read: CE low, 38, address 000010, data A5 3C 7E 01, CE high. Then CE low, EB, address 000010, 6 wait SCKs, 8 data SCKs. Required: read nibbles A,5,3,C,7,E,0,1. psram_io_en_o rises on the first fall after the 6th wait rise.
- Wrap: write 11 22 at address 0003FF (MEM_DEPTH=1024). Required: mem[3FF]=11, mem[000]=22. Read from 0003FF returns 11 then 22.
- Unsupported opcode: send 9F, toggle 10 SCKs with IO=F. Required: err_o high exactly 1 cycle after the 2nd command rise, psram_io_en_o stays 0, memory unchanged. A following write/read to 000020 succeeds.
- CE abort: write to 000040 with data B7 followed by only the high nibble C, then CE high. Required: mem[40]=B7, mem[41] keeps its preload 00. busy_o=0 one cycle after CE rises.
- Reset mid-read: assert rst_i for 1 cycle during RDAT. Required: psram_io_en_o=0 and busy_o=0 next cycle. A new EB read from 000010 after CE cycling returns A5.
- Wait-count variants: RD_WAIT=0 and WR_WAIT=2 builds. Required: first read nibble on the fall right after the 6th address rise. Write data is sampled starting at the 3rd rise after the address.
